instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch_pkg.sv | 8 +
 rtl/prefetch_fifo.sv | 66 ++++++
 rtl/instr_prefetch.sv | 79 +++++++
 tb/tb_instr_prefetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared CPU definitions: default widths and queue depth used by every pipeline stage.
package instr_prefetch_pkg;

  localparam int unsigned PcWDefault    = 5;
  localparam int unsigned InstrWDefault = 32;
  localparam int unsigned DepthDefault  = 4;

endpackage

// File: rtl/prefetch_fifo.sv
// Power-of-two FIFO with synchronous flush and an occupancy count; storage is not reset.
module prefetch_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_en, rd_en;

  always_comb begin
    // Flush dominates: a coincident push or pop is simply discarded.
    wr_en    = push_i & ~flush_i & (count_q != FullCnt);
    rd_en    = pop_i & ~flush_i & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AddrW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: issues ROM reads ahead of decode and buffers {pc, instr} in a FIFO.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned PC_W    = PcWDefault,
  parameter int unsigned INSTR_W = InstrWDefault,
  parameter int unsigned DEPTH   = DepthDefault
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned EntryW = PC_W + INSTR_W;

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [CntW-1:0]   count;
  logic [EntryW-1:0] head;
  logic              push, pop;

  assign out_valid = (count != '0);

  always_comb begin
    // Slots are reserved for the outstanding read; a same-cycle pop earns no credit.
    imem_req      = ~redirect && ((count + CntW'(inflight_q)) < CntW'(DEPTH));
    push          = inflight_q & ~redirect;
    pop           = out_valid & out_ready;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = imem_req;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (imem_req) begin
      fetch_pc_d    = fetch_pc_q + PC_W'(1);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  prefetch_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESET_N),
    .flush_i (redirect),
    .push_i  (push),
    .wdata_i ({inflight_pc_q, imem_rdata}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  assign imem_addr         = fetch_pc_q;
  assign {out_pc, out_instr} = head;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a one-cycle-latency ROM returning 0x1000_0000 + addr.
module tb_instr_prefetch;

  localparam int unsigned PcW    = 5;
  localparam int unsigned InstrW = 32;
  localparam int unsigned Depth  = 4;
  localparam int          Bound  = 12;

  logic              CLOCK_50 = 1'b0;
  logic              RESET_N = 1'b0;
  logic              redirect = 1'b0;
  logic [PcW-1:0]    redirect_pc = '0;
  logic              imem_req;
  logic [PcW-1:0]    imem_addr;
  logic [InstrW-1:0] imem_rdata = '0;
  logic              out_valid;
  logic [PcW-1:0]    out_pc;
  logic [InstrW-1:0] out_instr;
  logic              out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  instr_prefetch #(
    .PC_W    (PcW),
    .INSTR_W (InstrW),
    .DEPTH   (Depth)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    RESET_N   = 1'b0;
    redirect  = 1'b0;
    out_ready = rdy;
    tick();
    tick();
    RESET_N = 1'b1;
    #1;
  endtask

  // Advances until out_valid is seen (without consuming it) or the bound expires.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < Bound; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  initial begin
    logic [PcW-1:0] addrs[$];
    logic [PcW-1:0] pcs[$];
    logic [PcW-1:0] exp_seq[4];
    bit ok;

    // Reset release and streaming at full rate.
    do_reset(1'b1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("c0_req", 32'(imem_req), 32'd1);
    check("c0_addr", 32'(imem_addr), 32'd0);
    tick();
    check("c1_valid", 32'(out_valid), 32'd0);
    check("c1_addr", 32'(imem_addr), 32'd1);
    tick();
    check("c2_valid", 32'(out_valid), 32'd1);
    check("c2_pc", 32'(out_pc), 32'd0);
    check("c2_instr", out_instr, 32'h1000_0000);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_pc", 32'(out_pc), 32'(i));
      check("stream_instr", out_instr, 32'h1000_0000 + 32'(i));
    end

    // Backpressure: queue fills with exactly DEPTH requests, head held.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (imem_req) addrs.push_back(imem_addr);
      tick();
    end
    check("bp_nreq", 32'(addrs.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < addrs.size()) check("bp_addr", 32'(addrs[i]), 32'(i));
    end
    check("bp_req_off", 32'(imem_req), 32'd0);
    check("bp_head_pc", 32'(out_pc), 32'd0);
    check("bp_head_instr", out_instr, 32'h1000_0000);
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(ok);
      check("bp_drain_ok", 32'(ok), 32'd1);
      if (!ok) break;
      check("bp_drain_pc", 32'(out_pc), 32'(i));
      tick();
    end

    // Redirect with 3 queued and 1 in flight.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("rd_pre_valid", 32'(out_valid), 32'd1);
    check("rd_pre_req", 32'(imem_req), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 5'd17;
    #1;
    check("rd_req_suppr", 32'(imem_req), 32'd0);
    tick();
    redirect  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rd_flushed", 32'(out_valid), 32'd0);
    check("rd_addr", 32'(imem_addr), 32'd17);
    check("rd_req", 32'(imem_req), 32'd1);
    tick();
    check("rd_stale", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_valid", 32'(out_valid), 32'd1);
      check("rd_pc", 32'(out_pc), 32'd17 + 32'(i));
    end

    // PC wrap: 30, 31, 0, 1.
    redirect    = 1'b1;
    redirect_pc = 5'd30;
    tick();
    redirect = 1'b0;
    #1;
    exp_seq = '{5'd30, 5'd31, 5'd0, 5'd1};
    for (int i = 0; i < 4; i++) begin
      wait_valid(ok);
      check("wrap_ok", 32'(ok), 32'd1);
      if (!ok) break;
      check("wrap_pc", 32'(out_pc), 32'(exp_seq[i]));
      check("wrap_instr", out_instr, 32'h1000_0000 + 32'(exp_seq[i]));
      tick();
    end

    // Asynchronous reset mid-stream with the queue full.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_req", 32'(imem_req), 32'd0);
    @(posedge CLOCK_50);
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_addr", 32'(imem_addr), 32'd0);
    @(negedge CLOCK_50);
    RESET_N   = 1'b1;
    out_ready = 1'b1;
    #1;
    wait_valid(ok);
    check("post_rst_ok", 32'(ok), 32'd1);
    check("post_rst_pc", 32'(out_pc), 32'd0);

    // Redirect coincident with a pop and a pending push.
    for (int i = 0; i < 3; i++) tick();
    check("co_valid", 32'(out_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 5'd9;
    #1;
    check("co_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("co_empty", 32'(out_valid), 32'd0);
    wait_valid(ok);
    check("co_ok", 32'(ok), 32'd1);
    check("co_pc", 32'(out_pc), 32'd9);
    pcs.push_back(out_pc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
